ahb3lite_sram_arbiter: RTL and testbench



---
 rtl/ahb3lite_sram_arbiter.sv | 134 +++++++++++++
 tb/tb_ahb3lite_sram_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram_arbiter.sv
// Round-robin arbiter sharing one AHB3-Lite slave between MASTERS masters.
// A master preempted with a read in flight is served from a per-master hold buffer on regrant.
module ahb3lite_sram_arbiter #(
    parameter int MASTERS    = 2,
    parameter int HADDR_SIZE = 8,
    parameter int HDATA_SIZE = 32
) (
    input  logic                                  HRESETn,
    input  logic                                  HCLK,
    input  logic [MASTERS-1:0]                    mst_HSEL,
    input  logic [MASTERS-1:0]                    mst_HWRITE,
    input  logic [MASTERS-1:0]                    mst_HMASTLOCK,
    input  logic [MASTERS-1:0][HADDR_SIZE-1:0]    mst_HADDR,
    input  logic [MASTERS-1:0][HDATA_SIZE-1:0]    mst_HWDATA,
    input  logic [MASTERS-1:0][2:0]               mst_HSIZE,
    input  logic [MASTERS-1:0][2:0]               mst_HBURST,
    input  logic [MASTERS-1:0][3:0]               mst_HPROT,
    input  logic [MASTERS-1:0][1:0]               mst_HTRANS,
    output logic [MASTERS-1:0][HDATA_SIZE-1:0]    mst_HRDATA,
    output logic [MASTERS-1:0]                    mst_HREADYOUT,
    output logic [MASTERS-1:0]                    mst_HRESP,
    output logic                                  slv_HSEL,
    output logic                                  slv_HWRITE,
    output logic                                  slv_HMASTLOCK,
    output logic                                  slv_HREADY,
    output logic [HADDR_SIZE-1:0]                 slv_HADDR,
    output logic [HDATA_SIZE-1:0]                 slv_HWDATA,
    output logic [2:0]                            slv_HSIZE,
    output logic [2:0]                            slv_HBURST,
    output logic [3:0]                            slv_HPROT,
    output logic [1:0]                            slv_HTRANS,
    input  logic [HDATA_SIZE-1:0]                 slv_HRDATA,
    input  logic                                  slv_HREADYOUT,
    input  logic                                  slv_HRESP
);
    localparam int GW = $clog2(MASTERS);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    logic [GW-1:0]      r_g;
    logic               r_dv;
    logic [MASTERS-1:0] w_req;
    logic [MASTERS-1:0] w_bad;
    logic [GW-1:0]      w_rr;
    logic               w_rr_found;
    logic [1:0]         w_o_trans;
    logic               w_keep;
    logic               w_preempt;
    logic               w_handover;

    function automatic logic [GW-1:0] nxt(input logic [GW-1:0] b, input int k);
        int s;
        s = int'(b) + k;
        if (s >= MASTERS) s = s - MASTERS;
        return s[GW-1:0];
    endfunction

    // Nearest requester after the owner wins: scan from farthest to nearest.
    always_comb begin
        w_rr       = r_g;
        w_rr_found = 1'b0;
        for (int k = MASTERS-1; k >= 1; k--) begin
            if (w_req[nxt(r_g, k)]) begin
                w_rr       = nxt(r_g, k);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_o_trans = mst_HTRANS[r_g];
    assign w_keep    = (w_o_trans == HT_SEQ) || (w_o_trans == HT_BUSY) || mst_HMASTLOCK[r_g];

    // Preempting needs a data phase in flight, so every grant carries at least one transfer.
    assign w_preempt  = r_dv & w_req[r_g] & ~w_keep & w_rr_found & slv_HREADYOUT & ~slv_HRESP;
    assign w_handover = slv_HREADYOUT & ~w_keep & w_rr_found & (~w_req[r_g] | w_preempt);

    assign slv_HSEL      = mst_HSEL[r_g] & ~w_preempt;
    assign slv_HTRANS    = w_preempt ? HT_IDLE : w_o_trans;
    assign slv_HWRITE    = mst_HWRITE[r_g];
    assign slv_HMASTLOCK = mst_HMASTLOCK[r_g];
    assign slv_HADDR     = mst_HADDR[r_g];
    assign slv_HWDATA    = mst_HWDATA[r_g];
    assign slv_HSIZE     = mst_HSIZE[r_g];
    assign slv_HBURST    = mst_HBURST[r_g];
    assign slv_HPROT     = mst_HPROT[r_g];
    assign slv_HREADY    = slv_HREADYOUT;

    for (genvar m = 0; m < MASTERS; m++) begin : g_mst
        localparam logic [GW-1:0] IDX = GW'(m);
        logic                  w_own;
        logic                  r_hold_v;
        logic [HDATA_SIZE-1:0] r_hold_d;

        assign w_req[m] = mst_HSEL[m] & (mst_HTRANS[m] == HT_NONSEQ);
        assign w_own    = (r_g == IDX);
        assign w_bad[m] = ~w_own & mst_HSEL[m] & mst_HTRANS[m][0];

        assign mst_HREADYOUT[m] = w_own ? (slv_HREADYOUT & ~w_preempt) : ~w_req[m];
        assign mst_HRDATA[m]    = ~w_own ? '0 : (r_hold_v ? r_hold_d : slv_HRDATA);
        assign mst_HRESP[m]     = w_own & ~r_hold_v & slv_HRESP;

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                r_hold_v <= 1'b0;
                r_hold_d <= '0;
            end else if (w_own) begin
                if (w_preempt) begin
                    r_hold_v <= 1'b1;
                    r_hold_d <= slv_HRDATA;
                end else if (mst_HREADYOUT[m]) begin
                    r_hold_v <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_g  <= '0;
            r_dv <= 1'b0;
        end else begin
            if (slv_HREADYOUT) r_dv <= slv_HSEL & slv_HTRANS[1];
            if (w_handover)    r_g  <= w_rr;
        end
    end

`ifndef SYNTHESIS
    always @(posedge HCLK) begin
        if (HRESETn) assert (w_bad == '0) else $error("non-owner master issued SEQ/BUSY");
    end
`endif
endmodule

// File: tb/tb_ahb3lite_sram_arbiter.sv
// Directed bench for ahb3lite_sram_arbiter: per-cycle expectations are queued by the
// driver and compared by a negedge monitor against a small zero-wait SRAM slave model.
module tb_ahb3lite_sram_arbiter;
    localparam int X = -1;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic [1:0]       hsel = '0, hwrite = '0, hlock = '0;
    logic [1:0][7:0]  haddr = '0;
    logic [1:0][31:0] hwdata = '0;
    logic [1:0][2:0]  hsize = {3'b010, 3'b010}, hburst = '0;
    logic [1:0][3:0]  hprot = {4'b0011, 4'b0011};
    logic [1:0][1:0]  htrans = '0;

    logic [1:0][31:0] m_rdata;
    logic [1:0]       m_rdy, m_resp;
    logic             s_sel, s_write, s_lock, s_ready;
    logic [7:0]       s_addr;
    logic [31:0]      s_wdata, s_rdata;
    logic [2:0]       s_size, s_burst;
    logic [3:0]       s_prot;
    logic [1:0]       s_trans;
    logic             s_rdyout, s_resp;

    ahb3lite_sram_arbiter #(.MASTERS(2), .HADDR_SIZE(8), .HDATA_SIZE(32)) dut (
        .HRESETn(HRESETn), .HCLK(HCLK),
        .mst_HSEL(hsel), .mst_HWRITE(hwrite), .mst_HMASTLOCK(hlock),
        .mst_HADDR(haddr), .mst_HWDATA(hwdata), .mst_HSIZE(hsize),
        .mst_HBURST(hburst), .mst_HPROT(hprot), .mst_HTRANS(htrans),
        .mst_HRDATA(m_rdata), .mst_HREADYOUT(m_rdy), .mst_HRESP(m_resp),
        .slv_HSEL(s_sel), .slv_HWRITE(s_write), .slv_HMASTLOCK(s_lock),
        .slv_HREADY(s_ready), .slv_HADDR(s_addr), .slv_HWDATA(s_wdata),
        .slv_HSIZE(s_size), .slv_HBURST(s_burst), .slv_HPROT(s_prot),
        .slv_HTRANS(s_trans), .slv_HRDATA(s_rdata),
        .slv_HREADYOUT(s_rdyout), .slv_HRESP(s_resp)
    );

    // SRAM slave model; inj overrides the response for error cycles.
    logic [31:0] mem [256];
    logic        dp_v, dp_w;
    logic [7:0]  dp_a;
    logic        inj = 1'b0, inj_rdy = 1'b1, inj_resp = 1'b0;
    assign s_rdyout = inj ? inj_rdy : 1'b1;
    assign s_resp   = inj ? inj_resp : 1'b0;
    assign s_rdata  = (dp_v && !dp_w) ? mem[dp_a] : 32'h0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_v    <= 1'b0;
            dp_w    <= 1'b0;
            dp_a    <= '0;
            mem[4]  <= 32'h11223344;
            mem[8]  <= 32'h55667788;
        end else if (s_ready) begin
            if (dp_v && dp_w) mem[dp_a] <= s_wdata;
            dp_v <= s_sel && s_trans[1];
            dp_w <= s_write;
            dp_a <= s_addr;
        end
    end

    typedef struct {
        string  nm;
        int     st, sa, r0, r1, e0;
        longint d0, d1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0, n_bad = 0;

    task automatic exp(input string nm, input int st, input int sa, input int r0, input int r1,
                       input longint d0, input int e0, input longint d1);
        exp_t e;
        e.nm = nm; e.st = st; e.sa = sa; e.r0 = r0; e.r1 = r1; e.d0 = d0; e.e0 = e0; e.d1 = d1;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input string f, input longint want, input longint got);
        if (want >= 0) begin
            n_vec++;
            if (got != want) begin
                n_bad++;
                $display("FAIL %s %s: got %0h, want %0h", nm, f, got, want);
            end
        end
    endtask

    always @(negedge HCLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.nm, "slv_HTRANS", longint'(mon_e.st), longint'(s_trans));
            chk(mon_e.nm, "slv_HADDR",  longint'(mon_e.sa), longint'(s_addr));
            chk(mon_e.nm, "m0_HREADYOUT", longint'(mon_e.r0), longint'(m_rdy[0]));
            chk(mon_e.nm, "m1_HREADYOUT", longint'(mon_e.r1), longint'(m_rdy[1]));
            chk(mon_e.nm, "m0_HRDATA", mon_e.d0, longint'(m_rdata[0]));
            chk(mon_e.nm, "m0_HRESP",  longint'(mon_e.e0), longint'(m_resp[0]));
            chk(mon_e.nm, "m1_HRDATA", mon_e.d1, longint'(m_rdata[1]));
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mset(input int i, input logic [1:0] tr, input logic [7:0] a,
                        input logic w, input logic lk);
        hsel[i]   = (tr != 2'b00);
        htrans[i] = tr;
        haddr[i]  = a;
        hwrite[i] = w;
        hlock[i]  = lk;
    endtask

    localparam logic [1:0] I = 2'b00, N = 2'b10, S = 2'b11;

    initial begin
        tick(); tick();
        exp("reset", 0, X, 1, 1, 'h0, 0, 'h0); tick();
        HRESETn = 1'b1;

        // M0 alone: write then read back
        mset(0, N, 8'h10, 1, 0);                           exp("m0_wr", 2, 'h10, 1, 1, X, 0, X); tick();
        mset(0, N, 8'h10, 0, 0); hwdata[0] = 32'hA5A5A5A5; exp("m0_rd", 2, 'h10, 1, 1, X, 0, X); tick();
        mset(0, I, 8'h00, 0, 0);                           exp("m0_rdd", 0, X, 1, 1, 'hA5A5A5A5, 0, X); tick();

        // Fresh reset, simultaneous requests, then preempt with hold and regrant
        HRESETn = 1'b0; tick(); HRESETn = 1'b1;
        mset(0, N, 8'h04, 0, 0); mset(1, N, 8'h10, 0, 0); exp("both_req", 2, 'h04, 1, 0, X, 0, X); tick();
        mset(0, N, 8'h08, 0, 0);                          exp("preempt", 0, X, 0, 0, X, X, X); tick();
        exp("m1_grant", 2, 'h10, 0, 1, 'h0, X, X); tick();
        mset(1, I, 8'h00, 0, 0);                          exp("m1_data", 0, X, 0, 1, X, X, 'hA5A5A5A5); tick();
        exp("m0_regrant", 2, 'h08, 1, 1, 'h11223344, 0, X); tick();
        mset(0, I, 8'h00, 0, 0);                          exp("m0_after", 0, X, 1, 1, 'h55667788, 0, X); tick();

        // M1 INCR4 burst, M0 requesting from beat 2
        hburst[1] = 3'b011;
        mset(1, N, 8'h20, 1, 0);                          exp("bst_hand", 0, X, 1, 0, X, X, X); tick();
        exp("bst_b1", 2, 'h20, 1, 1, X, X, X); tick();
        mset(1, S, 8'h24, 1, 0); mset(0, N, 8'h30, 0, 0); exp("bst_b2", 3, 'h24, 0, 1, X, X, X); tick();
        mset(1, S, 8'h28, 1, 0);                          exp("bst_b3", 3, 'h28, 0, 1, X, X, X); tick();
        mset(1, S, 8'h2C, 1, 0);                          exp("bst_b4", 3, 'h2C, 0, 1, X, X, X); tick();
        mset(1, I, 8'h00, 0, 0); hburst[1] = 3'b000;      exp("bst_end", 0, X, 0, 1, X, X, X); tick();
        exp("bst_m0", 2, 'h30, 1, 1, X, X, X); tick();
        mset(0, I, 8'h00, 0, 0);                          exp("bst_idle", 0, X, 1, 1, X, X, X); tick();

        // Locked sequence: M1 must wait until HMASTLOCK drops
        mset(0, N, 8'h04, 0, 1); mset(1, N, 8'h10, 0, 0); exp("lk1", 2, 'h04, 1, 0, X, 0, X); tick();
        mset(0, N, 8'h08, 0, 1);                          exp("lk2", 2, 'h08, 1, 0, 'h11223344, 0, X); tick();
        mset(0, N, 8'h10, 0, 1);                          exp("lk3", 2, 'h10, 1, 0, 'h55667788, 0, X); tick();
        mset(0, I, 8'h00, 0, 0);                          exp("lk_rel", 0, X, 1, 0, 'hA5A5A5A5, 0, X); tick();
        exp("lk_m1", 2, 'h10, 1, 1, X, X, X); tick();
        mset(1, I, 8'h00, 0, 0);                          exp("lk_m1d", 0, X, 1, 1, X, X, 'hA5A5A5A5); tick();

        // Two-cycle ERROR to M0 while M1 waits
        mset(0, N, 8'h04, 0, 0);                          exp("er_hand", 0, X, 0, 1, X, X, X); tick();
        mset(1, N, 8'h10, 0, 0);                          exp("er_a", 2, 'h04, 1, 0, X, 0, X); tick();
        mset(0, N, 8'h08, 0, 0); inj = 1'b1; inj_rdy = 1'b0; inj_resp = 1'b1;
        exp("er_c1", 2, 'h08, 0, 0, X, 1, X); tick();
        inj_rdy = 1'b1;                                   exp("er_c2", 2, 'h08, 1, 0, X, 1, X); tick();
        inj = 1'b0; inj_resp = 1'b0; mset(0, I, 8'h00, 0, 0);
        exp("er_done", 0, X, 1, 0, 'h55667788, 0, X); tick();
        exp("er_m1", 2, 'h10, 1, 1, X, X, X); tick();
        mset(1, I, 8'h00, 0, 0);                          exp("er_m1d", 0, X, 1, 1, X, X, 'hA5A5A5A5); tick();

        // Reset mid-burst with held data pending for M0
        mset(0, N, 8'h04, 0, 0);                          exp("rs_hand", 0, X, 0, 1, X, X, X); tick();
        mset(1, N, 8'h40, 1, 0); hburst[1] = 3'b011;      exp("rs_m0", 2, 'h04, 1, 0, X, 0, X); tick();
        mset(0, N, 8'h08, 0, 0);                          exp("rs_pre", 0, X, 0, 0, X, X, X); tick();
        exp("rs_b1", 2, 'h40, 0, 1, X, X, X); tick();
        mset(1, S, 8'h44, 1, 0);                          exp("rs_b2", 3, 'h44, 0, 1, X, X, X); tick();
        HRESETn = 1'b0; mset(1, I, 8'h00, 0, 0); hburst[1] = 3'b000;
        exp("rs_async", 2, 'h08, 1, 1, 'h0, 0, X); tick();
        HRESETn = 1'b1;                                   exp("rs_rel", 2, 'h08, 1, 1, 'h0, 0, X); tick();
        mset(0, I, 8'h00, 0, 0);                          exp("rs_data", 0, X, 1, 1, 'h55667788, 0, X); tick();

        tick();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
